// File: rtl/fir_sample_sequencer.sv
// Multi-cycle 4-tap FIR sequencer: one accepted sample yields one saturated result
// plus a cnt_up pulse; flush clears tap history and emits a clear pulse.
module fir_sample_sequencer #(
  parameter int NTAPS = 4,
  parameter int DW    = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  data_ready,
  input  logic [DW-1:0]         sample_data,
  input  logic [NTAPS*DW-1:0]   coeffs,
  input  logic                  flush,
  output logic                  modwait,
  output logic                  cnt_up,
  output logic                  clear,
  output logic [DW-1:0]         fir_out,
  output logic                  err
);

  localparam int AW = DW + 2;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, DONE, FLUSH} state_t;

  state_t          state;
  logic [DW-1:0]   x0, x1, x2, x3;
  logic [AW-1:0]   acc;
  logic [DW-1:0]   mac_x;
  logic [DW-1:0]   mac_c;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   prod_hi;
  logic [AW-1:0]   sum;
  logic [DW:0]     sat_res;

  // Result of {overflow flag, clamped value} for the final unsigned sum.
  function automatic logic [DW:0] saturate(input logic [AW-1:0] s);
    if (s > AW'({DW{1'b1}}))
      return {1'b1, {DW{1'b1}}};
    else
      return {1'b0, s[DW-1:0]};
  endfunction

  always_comb begin
    mac_x = '0;
    mac_c = '0;
    case (state)
      MAC0: begin mac_x = x0; mac_c = coeffs[DW-1:0];      end
      MAC1: begin mac_x = x1; mac_c = coeffs[2*DW-1:DW];   end
      MAC2: begin mac_x = x2; mac_c = coeffs[3*DW-1:2*DW]; end
      MAC3: begin mac_x = x3; mac_c = coeffs[4*DW-1:3*DW]; end
      default: ;
    endcase
    prod    = mac_x * mac_c;
    prod_hi = DW'(prod >> DW);
    sum     = acc + AW'(prod_hi);
    sat_res = saturate(sum);
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      x3      <= '0;
      acc     <= '0;
      fir_out <= '0;
      err     <= 1'b0;
      modwait <= 1'b0;
      cnt_up  <= 1'b0;
      clear   <= 1'b0;
    end else begin
      modwait <= 1'b0;
      cnt_up  <= 1'b0;
      clear   <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            state   <= FLUSH;
            x0      <= '0;
            x1      <= '0;
            x2      <= '0;
            x3      <= '0;
            fir_out <= '0;
            err     <= 1'b0;
            clear   <= 1'b1;
          end else if (data_ready) begin
            state   <= MAC0;
            x3      <= x2;
            x2      <= x1;
            x1      <= x0;
            x0      <= sample_data;
            acc     <= '0;
            modwait <= 1'b1;
          end
        end
        MAC0: begin
          acc     <= sum;
          state   <= MAC1;
          modwait <= 1'b1;
        end
        MAC1: begin
          acc     <= sum;
          state   <= MAC2;
          modwait <= 1'b1;
        end
        MAC2: begin
          acc     <= sum;
          state   <= MAC3;
          modwait <= 1'b1;
        end
        MAC3: begin
          acc     <= sum;
          fir_out <= sat_res[DW-1:0];
          err     <= sat_res[DW];
          state   <= DONE;
          modwait <= 1'b1;
          cnt_up  <= 1'b1;
        end
        DONE:    state <= IDLE;
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
